// File: rtl/muldiv_issue_ctrl_if.sv
// Request/response handshake bundle between a requester and muldiv_issue_ctrl.
// The master side issues requests and consumes responses; the slave side is the controller.
`timescale 1ns/1ps
interface muldiv_issue_ctrl_if #(
  parameter int OP1_W = 32,
  parameter int OP2_W = 64,
  parameter int RES_W = 64
) ();
  logic             req_valid;
  logic             req_ready;
  logic             req_op;
  logic [OP1_W-1:0] req_a;
  logic [OP2_W-1:0] req_b;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [RES_W-1:0] rsp_result;
  logic             rsp_err;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_err
  );
endinterface

// File: rtl/muldiv_issue_ctrl.sv
// Issue/response sequencer for the sequential multiply/divide unit, with
// divide-by-zero and stuck-unit trapping. Define MULDIV_SKID_EN for a one-entry request skid.
`timescale 1ns/1ps
module muldiv_issue_ctrl #(
  parameter int OP1_W   = 32,
  parameter int OP2_W   = 64,
  parameter int RES_W   = 64,
  parameter int TIMEOUT = 40
) (
  input  logic               clock,
  input  logic               reset,
  muldiv_issue_ctrl_if.slave bus,
  output logic [OP1_W-1:0]   opera1,
  output logic [OP2_W-1:0]   opera2,
  output logic               muordi,
  output logic               start,
  input  logic [RES_W-1:0]   result,
  input  logic               valid
);
  // state | meaning
  // IDLE  | waiting for a request
  // ISSUE | start pulse to the unit
  // WAIT  | waiting for unit valid or timeout
  // RESP  | response held until rsp_ready
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MASK = CNT_W'(2);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [RES_W-1:0] rsp_result_q;
  logic             rsp_err_q;
  logic [OP1_W-1:0] src_a;
  logic [OP2_W-1:0] src_b;
  logic             src_op, src_avail, src_dz;
  logic             load, cap_ok, cap_to;

`ifdef MULDIV_SKID_EN
  logic             skid_full;
  logic [OP1_W-1:0] skid_a;
  logic [OP2_W-1:0] skid_b;
  logic             skid_op;
  logic             accept;

  // A buffered request always goes ahead of whatever is on the bus
  assign src_a         = skid_full ? skid_a  : bus.req_a;
  assign src_b         = skid_full ? skid_b  : bus.req_b;
  assign src_op        = skid_full ? skid_op : bus.req_op;
  assign src_avail     = skid_full | bus.req_valid;
  assign bus.req_ready = ~skid_full & ~reset;
  assign accept        = bus.req_valid & bus.req_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      skid_full <= 1'b0;
      skid_a    <= '0;
      skid_b    <= '0;
      skid_op   <= 1'b0;
    end else if (load && skid_full) begin
      skid_full <= 1'b0;
    end else if (accept && !(load && state == IDLE)) begin
      skid_full <= 1'b1;
      skid_a    <= bus.req_a;
      skid_b    <= bus.req_b;
      skid_op   <= bus.req_op;
    end
  end
`else
  assign src_a         = bus.req_a;
  assign src_b         = bus.req_b;
  assign src_op        = bus.req_op;
  assign src_avail     = bus.req_valid;
  assign bus.req_ready = (state == IDLE) & ~reset;
`endif

  assign src_dz         = src_op & (src_a == '0);
  assign start          = (state == ISSUE);
  assign bus.rsp_valid  = (state == RESP);
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_err    = rsp_err_q;

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    cap_ok    = 1'b0;
    cap_to    = 1'b0;
    case (state)
      IDLE: begin
        if (src_avail) begin
          load      = 1'b1;
          state_nxt = src_dz ? RESP : ISSUE;
        end
      end
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        // First two WAIT cycles ignore valid: it is still sticky from the previous op
        if (valid && cnt >= CNT_MASK) begin
          cap_ok    = 1'b1;
          state_nxt = RESP;
        end else if (cnt == CNT_LAST) begin
          cap_to    = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_nxt = IDLE;
`ifdef MULDIV_SKID_EN
          if (skid_full) begin
            load      = 1'b1;
            state_nxt = src_dz ? RESP : ISSUE;
          end
`endif
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      opera1       <= '0;
      opera2       <= '0;
      muordi       <= 1'b0;
      rsp_result_q <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ISSUE)
        cnt <= '0;
      else if (state == WAIT && cnt != CNT_MAX)
        cnt <= cnt + CNT_W'(1);
      if (load) begin
        opera1 <= src_a;
        opera2 <= src_b;
        muordi <= src_op;
        if (src_dz) begin
          rsp_result_q <= '1;
          rsp_err_q    <= 1'b1;
        end
      end
      if (cap_ok) begin
        rsp_result_q <= result;
        rsp_err_q    <= 1'b0;
      end
      if (cap_to) begin
        rsp_result_q <= '0;
        rsp_err_q    <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_muldiv_issue_ctrl.sv
// Scoreboard bench for muldiv_issue_ctrl with a behavioural 32-iteration mul/div unit model.
`timescale 1ns/1ps
module tb_muldiv_issue_ctrl;
  localparam int OP1_W = 32, OP2_W = 64, RES_W = 64, TIMEOUT = 40;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  muldiv_issue_ctrl_if #(.OP1_W(OP1_W), .OP2_W(OP2_W), .RES_W(RES_W)) bus ();

  logic [OP1_W-1:0] opera1;
  logic [OP2_W-1:0] opera2;
  logic             muordi;
  logic             start;
  logic [RES_W-1:0] result;
  logic             valid;

  muldiv_issue_ctrl #(.OP1_W(OP1_W), .OP2_W(OP2_W), .RES_W(RES_W), .TIMEOUT(TIMEOUT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus),
    .opera1(opera1),
    .opera2(opera2),
    .muordi(muordi),
    .start (start),
    .result(result),
    .valid (valid)
  );

  typedef struct {
    logic [RES_W-1:0] res;
    logic             err;
    int               cyc;
  } exp_t;

  exp_t sb[$];
  exp_t e_mon;
  int   compared = 0, mismatched = 0;
  int   cyc = 0, start_cnt = 0, start_cyc = -1;

  // unit model: valid 33 cycles after the start edge; lag keeps the old valid high a little longer
  logic             stuck = 1'b0;
  int               lag = 0;
  int               it = 0, clr = 0;
  logic             busy = 1'b0;
  logic [RES_W-1:0] res_p = '0;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      valid <= 1'b0; result <= '0; busy <= 1'b0; it <= 0; clr <= 0;
    end else if (start) begin
      busy <= 1'b1; it <= 32; clr <= lag;
      if (lag == 0) valid <= 1'b0;
      if (!muordi)
        res_p <= opera2 * 64'(opera1);
      else if (opera1 == '0)
        res_p <= '1;
      else
        res_p <= {32'(opera2 % 64'(opera1)), 32'(opera2 / 64'(opera1))};
    end else begin
      if (clr != 0) begin
        clr <= clr - 1;
        if (clr == 1) valid <= 1'b0;
      end
      if (busy) begin
        if (it == 1) begin
          busy <= 1'b0;
          if (!stuck) begin valid <= 1'b1; result <= res_p; end
        end else it <= it - 1;
      end
    end
  end

  always @(posedge clock) cyc <= cyc + 1;
  always @(negedge clock) if (start) begin start_cnt++; start_cyc = cyc; end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name, input string msg);
    compared++;
    mismatched++;
    $display("FAIL %s: %s (cycle %0d)", name, msg, cyc);
  endtask

  // monitor: a fresh response is rsp_valid not carried over from an unfinished stall
  logic prev_v = 1'b0, prev_r = 1'b0;
  always @(negedge clock) begin
    if (reset) begin
      prev_v = 1'b0; prev_r = 1'b0;
    end else begin
      if (bus.rsp_valid && !(prev_v && !prev_r)) begin
        if (sb.size() == 0)
          fail_now("unexpected_rsp", $sformatf("got result %0h with nothing expected", bus.rsp_result));
        else begin
          e_mon = sb.pop_front();
          chk("rsp_result", bus.rsp_result, e_mon.res);
          chk("rsp_err", 64'(bus.rsp_err), 64'(e_mon.err));
          if (e_mon.cyc != 0) chk("rsp_latency", 64'(cyc), 64'(e_mon.cyc));
        end
      end
      prev_v = bus.rsp_valid;
      prev_r = bus.rsp_ready;
    end
  end

  task automatic push_exp(input logic [63:0] res, input logic err, input int at);
    exp_t e;
    e.res = res; e.err = err; e.cyc = at;
    sb.push_back(e);
  endtask

  task automatic send(input logic op, input logic [31:0] a, input logic [63:0] b,
                      input logic [63:0] res, input logic err, input int lat, output int t);
    @(posedge clock); #1;
    bus.req_op = op; bus.req_a = a; bus.req_b = b; bus.req_valid = 1'b1;
    t = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (bus.req_ready) begin
        t = cyc;
        push_exp(res, err, (lat == 0) ? 0 : cyc + lat);
        break;
      end
    end
    if (t < 0) fail_now("accept_timeout", "req_ready never rose");
    @(posedge clock); #1 bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int i;
    i = 0;
    while ((sb.size() != 0 || bus.rsp_valid) && i < 300) begin
      @(negedge clock);
      i++;
    end
    if (i >= 300) fail_now("drain_timeout", "response never completed");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   t, t2, sc;
    logic acc2;
    bus.req_valid = 1'b0; bus.req_op = 1'b0; bus.req_a = '0; bus.req_b = '0;
    bus.rsp_ready = 1'b1;
    repeat (3) @(negedge clock);
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_start", 64'(start), 64'd0);
    chk("rst_opera2", opera2, 64'd0);
    reset = 1'b0;
    @(negedge clock);
    chk("idle_req_ready", 64'(bus.req_ready), 64'd1);

    // multiply 3*5
    sc = start_cnt;
    send(1'b0, 32'd3, 64'd5, 64'd15, 1'b0, 35, t);
    drain();
    chk("mul_start_count", 64'(start_cnt - sc), 64'd1);
    chk("mul_start_cycle", 64'(start_cyc), 64'(t + 1));

    // divide 100/7 -> remainder 2, quotient 14
    send(1'b1, 32'd7, 64'd100, 64'h0000_0002_0000_000E, 1'b0, 35, t);
    drain();

    // divide by zero: no start pulse
    sc = start_cnt;
    send(1'b1, 32'd0, 64'd123, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1, t);
    drain();
    chk("dz_start_count", 64'(start_cnt - sc), 64'd0);

    // valid still high from the divide and lingering two cycles past start
    lag = 2;
    send(1'b0, 32'd6, 64'd7, 64'd42, 1'b0, 35, t);
    drain();
    lag = 0;

    // stuck unit -> timeout
    stuck = 1'b1;
    send(1'b0, 32'd2, 64'd2, 64'd0, 1'b1, TIMEOUT + 2, t);
    drain();
    stuck = 1'b0;

    // back-pressure in RESP with a second request waiting
    bus.rsp_ready = 1'b0;
    send(1'b0, 32'd9, 64'd9, 64'd81, 1'b0, 35, t);
    for (int i = 0; i < 100 && !bus.rsp_valid; i++) @(negedge clock);
    @(posedge clock); #1;
    bus.req_op = 1'b1; bus.req_a = 32'd4; bus.req_b = 64'd50; bus.req_valid = 1'b1;
    acc2 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("stall_rsp_valid", 64'(bus.rsp_valid), 64'd1);
      chk("stall_rsp_result", bus.rsp_result, 64'd81);
      chk("stall_rsp_err", 64'(bus.rsp_err), 64'd0);
      chk("stall_opera1", 64'(opera1), 64'd9);
      chk("stall_opera2", opera2, 64'd9);
`ifdef MULDIV_SKID_EN
      if (bus.req_ready && !acc2) begin
        acc2 = 1'b1;
        push_exp(64'h0000_0002_0000_000C, 1'b0, 0);
      end
`else
      chk("stall_req_ready", 64'(bus.req_ready), 64'd0);
`endif
      @(posedge clock); #1;
      if (acc2) bus.req_valid = 1'b0;
    end
    bus.rsp_ready = 1'b1;
`ifdef MULDIV_SKID_EN
    if (!acc2) fail_now("skid_accept", "second request not taken during stall");
`else
    send(1'b1, 32'd4, 64'd50, 64'h0000_0002_0000_000C, 1'b0, 35, t2);
`endif
    drain();

    // reset in WAIT at cnt=10, then a clean operation
    send(1'b0, 32'd5, 64'd5, 64'd25, 1'b0, 35, t);
    while (cyc != t + 12) @(negedge clock);
    reset = 1'b1;
    #1;
    sb.delete();
    chk("arst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("arst_start", 64'(start), 64'd0);
    chk("arst_opera1", 64'(opera1), 64'd0);
    chk("arst_opera2", opera2, 64'd0);
    chk("arst_muordi", 64'(muordi), 64'd0);
    chk("arst_rsp_result", bus.rsp_result, 64'd0);
    chk("arst_rsp_err", 64'(bus.rsp_err), 64'd0);
    chk("arst_req_ready", 64'(bus.req_ready), 64'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("post_rst_req_ready", 64'(bus.req_ready), 64'd1);
    send(1'b0, 32'd8, 64'd8, 64'd64, 1'b0, 35, t);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
